matmul_systolic_engine: RTL and testbench

//  Parametrised output-stationary systolic matrix multiplier: C(NxM) = A(NxK) * B(KxM), or C += A*B.

---
 rtl/matmul_pkg.sv | 27 ++
 rtl/matmul_pe.sv | 67 ++++++
 rtl/matmul_systolic_engine.sv | 158 +++++++++++++++
 tb/tb_matmul_systolic_engine.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the systolic matrix multiplier: FSM encoding, operand/result
// packing offsets and saturation limits.
package matmul_pkg;

  localparam int MAX_DIM_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Bit offset of element [row][col] in a row-major packed MAX_DIM x MAX_DIM matrix.
  function automatic int elem_off(input int row, input int col, input int max_dim,
                                  input int width);
    return (row * max_dim + col) * width;
  endfunction

  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int width);
    return ~sat_max(width);
  endfunction

endpackage

// File: rtl/matmul_pe.sv
// Output-stationary MAC cell: registered a/b pass-through, sticky overflow flag.
// MATMUL_SATURATE_EN selects clamping instead of two's-complement wrap on overflow.
module matmul_pe
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  clr_acc_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [BUS_WIDTH-1:0]  acc_o,
  output logic                  flag_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [BUS_WIDTH-1:0]           prod_ext;
  logic [BUS_WIDTH:0]             sum;
  logic                           ovf;
  logic [BUS_WIDTH-1:0]           acc_d;

  assign prod     = (2*DATA_WIDTH)'($signed(a_i)) * (2*DATA_WIDTH)'($signed(b_i));
  assign prod_ext = BUS_WIDTH'(prod);
  // One guard bit: overflow when the guard and the sign bit disagree.
  assign sum      = {acc_o[BUS_WIDTH-1], acc_o} + {prod_ext[BUS_WIDTH-1], prod_ext};
  assign ovf      = sum[BUS_WIDTH] ^ sum[BUS_WIDTH-1];

`ifdef MATMUL_SATURATE_EN
  localparam logic [BUS_WIDTH-1:0] SAT_POS = BUS_WIDTH'(sat_max(BUS_WIDTH));
  localparam logic [BUS_WIDTH-1:0] SAT_NEG = BUS_WIDTH'(sat_min(BUS_WIDTH));

  always_comb begin
    acc_d = sum[BUS_WIDTH-1:0];
    if (ovf) acc_d = sum[BUS_WIDTH] ? SAT_NEG : SAT_POS;
  end
`else
  assign acc_d = sum[BUS_WIDTH-1:0];
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_o    <= '0;
      b_o    <= '0;
      acc_o  <= '0;
      flag_o <= 1'b0;
    end else if (clr_i) begin
      a_o <= '0;
      b_o <= '0;
      if (clr_acc_i) begin
        acc_o  <= '0;
        flag_o <= 1'b0;
      end
    end else if (en_i) begin
      a_o    <= a_i;
      b_o    <= b_i;
      acc_o  <= acc_d;
      flag_o <= flag_o | ovf;
    end
  end

endmodule

// File: rtl/matmul_systolic_engine.sv
// Output-stationary systolic multiplier C = A*B or C += A*B with runtime N/K/M.
// Build option MATMUL_SATURATE_EN makes the PEs clamp on overflow instead of wrapping.
module matmul_systolic_engine
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int MAX_DIM    = MAX_DIM_DEF,
  localparam int DIM_W     = $clog2(MAX_DIM + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  start_i,
  input  logic                                  mode_i,
  input  logic [DIM_W-1:0]                      n_dim_i,
  input  logic [DIM_W-1:0]                      k_dim_i,
  input  logic [DIM_W-1:0]                      m_dim_i,
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] a_matrix_i,
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] b_matrix_i,
  output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]  c_matrix_o,
  output logic [MAX_DIM*MAX_DIM-1:0]            flags_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  err_o
);

  // Handshake: start_i is taken only in IDLE; busy_o rises on the following cycle and stays
  // high until done_o pulses for one cycle (with err_o on illegal dims). A held start_i
  // launches again on the first IDLE edge after done_o.
  localparam int CNT_W = $clog2(3 * MAX_DIM);
  localparam int OPW   = MAX_DIM * MAX_DIM * DATA_WIDTH;

  state_t                state;
  logic [DIM_W-1:0]      n_q, k_q, m_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt_q, last_cnt;
  logic [OPW-1:0]        a_q, b_q;
  logic [DATA_WIDTH-1:0] feed_a_q [MAX_DIM];
  logic [DATA_WIDTH-1:0] feed_b_q [MAX_DIM];
  logic [DATA_WIDTH-1:0] feed_a_d [MAX_DIM];
  logic [DATA_WIDTH-1:0] feed_b_d [MAX_DIM];
  logic                  dims_ok, accept;

  assign dims_ok = (n_dim_i != '0) && (n_dim_i <= DIM_W'(MAX_DIM)) &&
                   (k_dim_i != '0) && (k_dim_i <= DIM_W'(MAX_DIM)) &&
                   (m_dim_i != '0) && (m_dim_i <= DIM_W'(MAX_DIM));
  assign accept   = (state == IDLE) && start_i;
  assign last_cnt = CNT_W'(n_q) + CNT_W'(k_q) + CNT_W'(m_q) - CNT_W'(2);

  // Skewed edge feeds: row i carries A[i][t-i], column j carries B[t-j][j].
  always_comb begin
    for (int i = 0; i < MAX_DIM; i++) begin
      feed_a_d[i] = '0;
      feed_b_d[i] = '0;
    end
    for (int i = 0; i < MAX_DIM; i++) begin
      for (int kk = 0; kk < MAX_DIM; kk++) begin
        if (i < int'(n_q) && kk < int'(k_q) && int'(cnt_q) == i + kk)
          feed_a_d[i] = a_q[elem_off(i, kk, MAX_DIM, DATA_WIDTH) +: DATA_WIDTH];
        if (i < int'(m_q) && kk < int'(k_q) && int'(cnt_q) == i + kk)
          feed_b_d[i] = b_q[elem_off(kk, i, MAX_DIM, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      n_q    <= '0;
      k_q    <= '0;
      m_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++) begin
        feed_a_q[i] <= '0;
        feed_b_q[i] <= '0;
      end
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            n_q    <= n_dim_i;
            k_q    <= k_dim_i;
            m_q    <= m_dim_i;
            a_q    <= a_matrix_i;
            b_q    <= b_matrix_i;
            cnt_q  <= '0;
            busy_o <= 1'b1;
            err_q  <= !dims_ok;
            for (int i = 0; i < MAX_DIM; i++) begin
              feed_a_q[i] <= '0;
              feed_b_q[i] <= '0;
            end
            state <= dims_ok ? COMPUTE : DONE;
          end
        end
        COMPUTE: begin
          for (int i = 0; i < MAX_DIM; i++) begin
            feed_a_q[i] <= feed_a_d[i];
            feed_b_q[i] <= feed_b_d[i];
          end
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == last_cnt) state <= DONE;
        end
        DONE: begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
          err_o  <= err_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] a_pass [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] b_pass [MAX_DIM][MAX_DIM];

  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
      logic [DATA_WIDTH-1:0] a_in, b_in;
      if (gj == 0) begin : g_a_edge
        assign a_in = feed_a_q[gi];
      end else begin : g_a_inner
        assign a_in = a_pass[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in = feed_b_q[gj];
      end else begin : g_b_inner
        assign b_in = b_pass[gi-1][gj];
      end
      matmul_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .BUS_WIDTH (BUS_WIDTH)
      ) u_pe (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (accept),
        .clr_acc_i(accept && dims_ok && !mode_i),
        .en_i     (state == COMPUTE),
        .a_i      (a_in),
        .b_i      (b_in),
        .a_o      (a_pass[gi][gj]),
        .b_o      (b_pass[gi][gj]),
        .acc_o    (c_matrix_o[(gi*MAX_DIM+gj)*BUS_WIDTH +: BUS_WIDTH]),
        .flag_o   (flags_o[gi*MAX_DIM+gj])
      );
    end
  end

endmodule

// File: tb/tb_matmul_systolic_engine.sv
// Self-checking bench for matmul_systolic_engine against a plain-arithmetic matrix model.
module tb_matmul_systolic_engine;

  localparam int MD    = 4;
  localparam int DW    = 8;
  localparam int BW    = 16;
  localparam int DIM_W = $clog2(MD + 1);
  localparam int AW    = MD * MD * DW;
  localparam int CW    = MD * MD * BW;
  localparam int FW    = MD * MD;
`ifdef MATMUL_SATURATE_EN
  localparam bit SAT  = 1'b1;
  localparam int T4_C = 32767;
`else
  localparam bit SAT  = 1'b0;
  localparam int T4_C = -1020;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic             mode_i = 1'b0;
  logic [DIM_W-1:0] n_dim_i = '0, k_dim_i = '0, m_dim_i = '0;
  logic [AW-1:0]    a_matrix_i = '0, b_matrix_i = '0;
  logic [CW-1:0]    c_matrix_o;
  logic [FW-1:0]    flags_o;
  logic             busy_o, done_o, err_o;

  matmul_systolic_engine #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .MAX_DIM(MD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i),
    .a_matrix_i(a_matrix_i), .b_matrix_i(b_matrix_i), .c_matrix_o(c_matrix_o),
    .flags_o(flags_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int ma [MD][MD];
  int mb [MD][MD];
  int mc [MD][MD];
  bit mf [MD][MD];
  logic [CW+FW-1:0] exp_q [$];

  function automatic void model_run(input bit mode, input int n, input int k, input int m);
    int acc, s;
    if (n < 1 || n > MD || k < 1 || k > MD || m < 1 || m > MD) return;
    if (!mode)
      for (int i = 0; i < MD; i++)
        for (int j = 0; j < MD; j++) begin
          mc[i][j] = 0;
          mf[i][j] = 1'b0;
        end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < m; j++) begin
        acc = mc[i][j];
        for (int kk = 0; kk < k; kk++) begin
          s = acc + ma[i][kk] * mb[kk][j];
          if (s > 32767) begin
            mf[i][j] = 1'b1;
            acc = SAT ? 32767 : s - 65536;
          end else if (s < -32768) begin
            mf[i][j] = 1'b1;
            acc = SAT ? -32768 : s + 65536;
          end else acc = s;
        end
        mc[i][j] = acc;
      end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++) begin
        mc[i][j] = 0;
        mf[i][j] = 1'b0;
      end
  endfunction

  function automatic logic [AW-1:0] pack_a();
    logic [AW-1:0] v;
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++) v[(i*MD+j)*DW +: DW] = DW'(ma[i][j]);
    return v;
  endfunction

  function automatic logic [AW-1:0] pack_b();
    logic [AW-1:0] v;
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++) v[(i*MD+j)*DW +: DW] = DW'(mb[i][j]);
    return v;
  endfunction

  function automatic logic [CW-1:0] exp_c();
    logic [CW-1:0] v;
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++) v[(i*MD+j)*BW +: BW] = BW'(mc[i][j]);
    return v;
  endfunction

  function automatic logic [FW-1:0] exp_f();
    logic [FW-1:0] v;
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++) v[i*MD+j] = mf[i][j];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_rand();
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++) begin
        ma[i][j] = int'($urandom_range(0, 255)) - 128;
        mb[i][j] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic load_dut(input bit mode, input int n, input int k, input int m);
    mode_i     = mode;
    n_dim_i    = DIM_W'(n);
    k_dim_i    = DIM_W'(k);
    m_dim_i    = DIM_W'(m);
    a_matrix_i = pack_a();
    b_matrix_i = pack_b();
  endtask

  // Pulses start, waits for done_o; cyc = edges after acceptance (0 on timeout).
  task automatic run_op(input bit noise, output int cyc, output bit err_seen, output bit busy_ok);
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i  = 1'b0;
    busy_ok  = busy_o;
    cyc      = 0;
    err_seen = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk_i);
      #1;
      if (done_o) begin
        cyc      = c;
        err_seen = err_o;
        break;
      end
      if (!busy_o) busy_ok = 1'b0;
      if (noise) start_i = 1'($urandom_range(0, 1));
    end
    start_i = 1'b0;
    if (busy_o) busy_ok = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (c_matrix_o !== '0) begin errors++; $display("FAIL reset_c got %h exp 0", c_matrix_o); end
    checks++; if (flags_o !== '0) begin errors++; $display("FAIL reset_flags got %h exp 0", flags_o); end
    checks++; if ({busy_o, done_o, err_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000", {busy_o, done_o, err_o});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_clear();
  endtask

  task automatic setup_identity();
    fill_rand();
    ma[0][0] = 1; ma[0][1] = 0; ma[1][0] = 0; ma[1][1] = 1;
    mb[0][0] = 1; mb[0][1] = 2; mb[1][0] = 3; mb[1][1] = 4;
  endtask

  task automatic test_identity();
    int cyc; bit e, bok;
    setup_identity();
    model_run(1'b0, 2, 2, 2);
    load_dut(1'b0, 2, 2, 2);
    run_op(1'b0, cyc, e, bok);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL ident_latency got %0d exp 6", cyc); end
    checks++; if (e !== 1'b0 || bok !== 1'b1) begin errors++; $display("FAIL ident_hs got err=%b busy_ok=%b exp 0 1", e, bok); end
    checks++; if (c_matrix_o !== exp_c()) begin errors++; $display("FAIL ident_c got %h exp %h", c_matrix_o, exp_c()); end
    checks++; if ($signed(c_matrix_o[(1*MD+1)*BW +: BW]) !== 16'sd4) begin
      errors++; $display("FAIL ident_c11 got %0d exp 4", $signed(c_matrix_o[(1*MD+1)*BW +: BW]));
    end
    checks++; if (flags_o !== '0) begin errors++; $display("FAIL ident_flags got %h exp 0", flags_o); end
    @(posedge clk_i);
    #1;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", done_o); end
  endtask

  task automatic test_col_row();
    int cyc; bit e, bok;
    fill_rand();
    ma[0][0] = 1; ma[1][0] = 2; ma[2][0] = 3;
    mb[0][0] = -1; mb[0][1] = 5;
    model_run(1'b0, 3, 1, 2);
    load_dut(1'b0, 3, 1, 2);
    run_op(1'b0, cyc, e, bok);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL colrow_latency got %0d exp 6", cyc); end
    checks++; if (c_matrix_o !== exp_c()) begin errors++; $display("FAIL colrow_c got %h exp %h", c_matrix_o, exp_c()); end
    checks++; if ($signed(c_matrix_o[(2*MD+1)*BW +: BW]) !== 16'sd15) begin
      errors++; $display("FAIL colrow_c21 got %0d exp 15", $signed(c_matrix_o[(2*MD+1)*BW +: BW]));
    end
  endtask

  task automatic test_accumulate();
    int cyc; bit e, bok;
    setup_identity();
    model_run(1'b0, 2, 2, 2);
    load_dut(1'b0, 2, 2, 2);
    run_op(1'b0, cyc, e, bok);
    model_run(1'b1, 2, 2, 2);
    load_dut(1'b1, 2, 2, 2);
    run_op(1'b0, cyc, e, bok);
    checks++; if (c_matrix_o !== exp_c()) begin errors++; $display("FAIL accum_c got %h exp %h", c_matrix_o, exp_c()); end
    checks++; if ($signed(c_matrix_o[(1*MD+0)*BW +: BW]) !== 16'sd6) begin
      errors++; $display("FAIL accum_c10 got %0d exp 6", $signed(c_matrix_o[(1*MD+0)*BW +: BW]));
    end
    checks++; if (flags_o !== '0) begin errors++; $display("FAIL accum_flags got %h exp 0", flags_o); end
  endtask

  task automatic test_overflow();
    int cyc; bit e, bok;
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++) begin
        ma[i][j] = 127;
        mb[i][j] = 127;
      end
    model_run(1'b0, 4, 4, 4);
    load_dut(1'b0, 4, 4, 4);
    run_op(1'b0, cyc, e, bok);
    checks++; if (cyc !== 12) begin errors++; $display("FAIL ovf_latency got %0d exp 12", cyc); end
    checks++; if (flags_o !== {FW{1'b1}}) begin errors++; $display("FAIL ovf_flags got %h exp all ones", flags_o); end
    checks++; if ($signed(c_matrix_o[(2*MD+3)*BW +: BW]) !== BW'(T4_C)) begin
      errors++; $display("FAIL ovf_c23 got %0d exp %0d", $signed(c_matrix_o[(2*MD+3)*BW +: BW]), T4_C);
    end
    checks++; if (c_matrix_o !== exp_c()) begin errors++; $display("FAIL ovf_c got %h exp %h", c_matrix_o, exp_c()); end
  endtask

  task automatic test_illegal();
    int cyc; bit e, bok;
    fill_rand();
    model_run(1'b0, 2, 0, 3);
    load_dut(1'b0, 2, 0, 3);
    run_op(1'b1, cyc, e, bok);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL ill_latency got %0d exp 1", cyc); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL ill_err got %b exp 1", e); end
    checks++; if (c_matrix_o !== exp_c() || flags_o !== exp_f()) begin
      errors++; $display("FAIL ill_keep got %h/%h exp %h/%h", c_matrix_o, flags_o, exp_c(), exp_f());
    end
    model_run(1'b0, 5, 1, 1);
    load_dut(1'b0, 5, 1, 1);
    run_op(1'b0, cyc, e, bok);
    checks++; if (cyc !== 1 || e !== 1'b1 || c_matrix_o !== exp_c()) begin
      errors++; $display("FAIL ill_big got cyc=%0d err=%b exp cyc=1 err=1", cyc, e);
    end
    // Legal run with spurious start pulses while busy.
    fill_rand();
    model_run(1'b1, 3, 3, 3);
    load_dut(1'b1, 3, 3, 3);
    run_op(1'b1, cyc, e, bok);
    checks++; if (cyc !== 9 || e !== 1'b0 || bok !== 1'b1) begin
      errors++; $display("FAIL noise_hs got cyc=%0d err=%b busy_ok=%b exp 9 0 1", cyc, e, bok);
    end
    checks++; if (c_matrix_o !== exp_c() || flags_o !== exp_f()) begin
      errors++; $display("FAIL noise_c got %h/%h exp %h/%h", c_matrix_o, flags_o, exp_c(), exp_f());
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit e, bok, seen;
    fill_rand();
    load_dut(1'b1, 4, 4, 4);
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    checks++; if (c_matrix_o !== '0 || flags_o !== '0) begin
      errors++; $display("FAIL midrst_clear got %h/%h exp 0/0", c_matrix_o, flags_o);
    end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got busy=%b done=%b exp 0 0", busy_o, done_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 1'b0;
    repeat (16) begin
      @(posedge clk_i);
      #1;
      if (done_o) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_nodone got %b exp 0", seen); end
    model_clear();
    fill_rand();
    model_run(1'b0, 4, 2, 3);
    load_dut(1'b0, 4, 2, 3);
    run_op(1'b0, cyc, e, bok);
    checks++; if (cyc !== 9 || c_matrix_o !== exp_c() || flags_o !== exp_f()) begin
      errors++; $display("FAIL midrst_fresh got cyc=%0d c=%h exp cyc=9 c=%h", cyc, c_matrix_o, exp_c());
    end
  endtask

  task automatic test_random();
    int cyc, n, k, m, lat; bit e, bok, md, legal;
    logic [CW+FW-1:0] exp;
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(1, MD); k = $urandom_range(1, MD); m = $urandom_range(1, MD);
      if ($urandom_range(0, 7) == 0) k = $urandom_range(0, 1) ? 0 : MD + 1;
      md = 1'($urandom_range(0, 1));
      legal = (k >= 1 && k <= MD);
      lat = legal ? n + k + m : 1;
      fill_rand();
      model_run(md, n, k, m);
      exp_q.push_back({exp_c(), exp_f()});
      load_dut(md, n, k, m);
      run_op(1'b0, cyc, e, bok);
      checks++; if (cyc !== lat || e !== !legal) begin
        errors++; $display("FAIL rand%0d_hs got cyc=%0d err=%b exp cyc=%0d err=%b", it, cyc, e, lat, !legal);
      end
      exp = exp_q.pop_front();
      checks++; if ({c_matrix_o, flags_o} !== exp) begin
        errors++; $display("FAIL rand%0d_c got %h exp %h", it, {c_matrix_o, flags_o}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n1, k1, m1, n2, k2, m2, cyc;
    logic [AW-1:0] a1, b1, a2, b2;
    logic [CW+FW-1:0] exp;
    n1 = $urandom_range(1, MD); k1 = $urandom_range(1, MD); m1 = $urandom_range(1, MD);
    n2 = $urandom_range(1, MD); k2 = $urandom_range(1, MD); m2 = $urandom_range(1, MD);
    fill_rand();
    a1 = pack_a(); b1 = pack_b();
    model_run(1'b0, n1, k1, m1);
    exp_q.push_back({exp_c(), exp_f()});
    fill_rand();
    a2 = pack_a(); b2 = pack_b();
    model_run(1'b1, n2, k2, m2);
    exp_q.push_back({exp_c(), exp_f()});
    @(negedge clk_i);
    mode_i = 1'b0; n_dim_i = DIM_W'(n1); k_dim_i = DIM_W'(k1); m_dim_i = DIM_W'(m1);
    a_matrix_i = a1; b_matrix_i = b1;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    // Operands for the second job change while the first is computing.
    mode_i = 1'b1; n_dim_i = DIM_W'(n2); k_dim_i = DIM_W'(k2); m_dim_i = DIM_W'(m2);
    a_matrix_i = a2; b_matrix_i = b2;
    for (int job = 0; job < 2; job++) begin
      cyc = 0;
      for (int c = 1; c <= 100; c++) begin
        @(posedge clk_i);
        #1;
        if (done_o) begin cyc = c; break; end
      end
      if (job == 1) start_i = 1'b0;
      checks++; if (cyc !== (job == 0 ? n1 + k1 + m1 : 1 + n2 + k2 + m2)) begin
        errors++; $display("FAIL b2b%0d_latency got %0d", job, cyc);
      end
      exp = exp_q.pop_front();
      checks++; if ({c_matrix_o, flags_o} !== exp) begin
        errors++; $display("FAIL b2b%0d_c got %h exp %h", job, {c_matrix_o, flags_o}, exp);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_identity();
    test_col_row();
    test_accumulate();
    test_overflow();
    test_illegal();
    test_reset_mid();
    test_random();
    test_back_to_back();
    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
